// File: rtl/gpio_bus_bridge.sv
// gpio_bus_bridge: core valid/ready load/store port to GPIO strobe interface, one access outstanding.
// Define GPIO_BRIDGE_SHADOW_EN to answer DATA/DIR loads from local shadow copies without a strobe.
module gpio_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        gpio_en,
  output logic        write_enable,
  output logic [31:0] gpio_addr,
  output logic [31:0] gpio_in,
  input  logic [31:0] gpio_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STROBE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [11:0] OFS_DATA = 12'h000;
  localparam logic [11:0] OFS_DIR  = 12'h004;
  localparam logic [11:0] OFS_READ = 12'h008;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [11:0] ofs;
  logic        hit;
  logic        legal;

  // Decode sees the request fields on the very edge they are latched, so errors reach RESP in one cycle.
  always_comb begin
    ofs   = req_addr[11:0];
    hit   = ((req_addr & ADDR_MASK) == BASE_ADDR);
    legal = hit && ((ofs == OFS_DATA) || (ofs == OFS_DIR) ||
                    ((ofs == OFS_READ) && !req_we));
  end

`ifdef GPIO_BRIDGE_SHADOW_EN
  logic [31:0] sh_data_q, sh_data_d;
  logic [31:0] sh_dir_q, sh_dir_d;
  logic        sh_hit;
  logic [31:0] sh_val;

  always_comb begin
    sh_data_d = sh_data_q;
    sh_dir_d  = sh_dir_q;
    if ((state_q == IDLE) && req_valid && legal && req_we) begin
      if (ofs == OFS_DATA) sh_data_d = req_wdata;
      if (ofs == OFS_DIR)  sh_dir_d  = req_wdata;
    end
    sh_hit = legal && !req_we && (ofs != OFS_READ);
    sh_val = (ofs == OFS_DIR) ? sh_dir_q : sh_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data_q <= '0;
      sh_dir_q  <= '0;
    end else begin
      sh_data_q <= sh_data_d;
      sh_dir_q  <= sh_dir_d;
    end
  end
`else
  logic        sh_hit;
  logic [31:0] sh_val;

  assign sh_hit = 1'b0;
  assign sh_val = '0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = !legal;
          rdata_d = sh_hit ? sh_val : '0;
          state_d = (!legal || sh_hit) ? RESP : STROBE;
        end
      end
      STROBE:  state_d = we_q ? RESP : CAPTURE;
      CAPTURE: begin
        rdata_d = gpio_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state flop so an async reset kills them immediately.
  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign gpio_en      = (state_q == STROBE);
  assign write_enable = (state_q == STROBE) && we_q;
  assign gpio_addr    = addr_q;
  assign gpio_in      = wdata_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_gpio_bus_bridge.sv
// Directed bench for gpio_bus_bridge: expected responses queued at request time, checked at response handshake.
module tb_gpio_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        gpio_en, write_enable;
  logic [31:0] gpio_addr, gpio_in;
  logic [31:0] gpio_rdata = 32'h0;

  gpio_bus_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .gpio_en(gpio_en), .write_enable(write_enable),
    .gpio_addr(gpio_addr), .gpio_in(gpio_in), .gpio_rdata(gpio_rdata)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] pop_e;
  int          strobe_cnt = 0;
  logic        prev_en = 1'b0;
  logic        stb_we = 1'b0;
  logic [31:0] stb_addr = 32'h0;
  logic [31:0] stb_in = 32'h0;
  logic [31:0] model_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // GPIO block model: read data appears only in the cycle right after a read strobe.
  always @(posedge clk) begin
    if (gpio_en && !write_enable) gpio_rdata <= model_rd;
    else                          gpio_rdata <= 32'hDEAD_0000;
  end

  always @(negedge clk) begin
    if (gpio_en) begin
      chk("strobe_back_to_back", {31'd0, prev_en}, 32'd0);
      strobe_cnt++;
      stb_we   = write_enable;
      stb_addr = gpio_addr;
      stb_in   = gpio_in;
    end
    prev_en = gpio_en;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        pop_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, pop_e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, pop_e[32]});
      end
    end
  end

  // Called at posedge+1 with the bridge idle; returns at posedge+1 after the response handshake.
  task automatic send(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input logic [31:0] er, input logic ee, input int nstb);
    int base;
    int cyc;
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    exp_q.push_back({ee, er});
    base = strobe_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    @(posedge clk); #1;
    chk({tag, "_strobes"}, 32'(strobe_cnt - base), 32'(nstb));
    if (nstb > 0) begin
      chk({tag, "_stb_we"}, {31'd0, stb_we}, {31'd0, we});
      chk({tag, "_stb_addr"}, stb_addr, a);
      if (we) chk({tag, "_stb_in"}, stb_in, d);
    end
  endtask

  int base;
  int cyc;

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_gpio_en", {31'd0, gpio_en}, 32'd0);
    chk("rst_write_enable", {31'd0, write_enable}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_gpio_addr", gpio_addr, 32'h0);
    chk("rst_gpio_in", gpio_in, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send("st_dir", 1'b1, 32'h2000_0004, 32'hAAAA_AAAA, 2, 32'h0, 1'b0, 1);
    model_rd = 32'hCAFE_BABE;
    send("ld_read", 1'b0, 32'h2000_0008, 32'h0, 3, 32'hCAFE_BABE, 1'b0, 1);

    send("err_miss", 1'b0, 32'h3000_0000, 32'h0, 1, 32'h0, 1'b1, 0);
    send("err_st_ro", 1'b1, 32'h2000_0008, 32'h5555_5555, 1, 32'h0, 1'b1, 0);
    send("err_unalign", 1'b0, 32'h2000_0002, 32'h0, 1, 32'h0, 1'b1, 0);
    send("err_ofs", 1'b0, 32'h2000_000C, 32'h0, 1, 32'h0, 1'b1, 0);

    send("st_data", 1'b1, 32'h2000_0000, 32'h1234_ABCD, 2, 32'h0, 1'b0, 1);
    model_rd = 32'h5A5A_0F0F;
`ifdef GPIO_BRIDGE_SHADOW_EN
    send("ld_data", 1'b0, 32'h2000_0000, 32'h0, 1, 32'h1234_ABCD, 1'b0, 0);
`else
    send("ld_data", 1'b0, 32'h2000_0000, 32'h0, 3, 32'h5A5A_0F0F, 1'b0, 1);
`endif

    // Backpressure: response stalls five cycles while a second request waits.
    rsp_ready = 1'b0;
    model_rd  = 32'h1111_2222;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h2000_0008;
    req_wdata = 32'h0;
    exp_q.push_back({1'b0, 32'h1111_2222});
    base = strobe_cnt;
    @(posedge clk); #1;
    cyc = 1;
    while (!rsp_valid && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 32'd3);
    model_rd = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1111_2222);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_strobes", 32'(strobe_cnt - base), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h3333_4444});
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp2_latency", 32'(cyc), 32'd3);
    @(posedge clk); #1;
    chk("bp2_strobes", 32'(strobe_cnt - base), 32'd2);

    // Reset in the middle of a store strobe.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h2000_0000;
    req_wdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_pre_en", {31'd0, gpio_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_gpio_en", {31'd0, gpio_en}, 32'd0);
    chk("rst_mid_we", {31'd0, write_enable}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_gpio_addr", gpio_addr, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    model_rd = 32'h0BAD_F00D;
    send("post_rst_ld", 1'b0, 32'h2000_0008, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 1);
    model_rd = 32'h0000_00F0;
`ifdef GPIO_BRIDGE_SHADOW_EN
    send("post_rst_dir", 1'b0, 32'h2000_0004, 32'h0, 1, 32'h0, 1'b0, 0);
`else
    send("post_rst_dir", 1'b0, 32'h2000_0004, 32'h0, 3, 32'h0000_00F0, 1'b0, 1);
`endif

    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
